// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch/JALR operand stalls, plus an
// optional divide hold enabled by defining HAZARD_DIV_HOLD_EN.
module hazard_ctrl #(
  parameter int DIV_LAT_MAX = 34
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rd_ex,
  input  logic       reg_write_ex,
  input  logic       mem_to_reg_ex,
  input  logic [4:0] rd_mem,
  input  logic       mem_to_reg_mem,
  input  logic       div_start_ex,
  input  logic       div_done,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       stall
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
`ifdef HAZARD_DIV_HOLD_EN
  localparam logic [1:0] DIV_WAIT = 2'd2;
  localparam logic [5:0] DIV_LIM  = 6'(DIV_LAT_MAX - 1);
`else
  localparam int div_lat_unused = DIV_LAT_MAX;
  logic div_in_unused;
  assign div_in_unused = div_start_ex ^ div_done;
`endif

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  logic [1:0] state_q, state_d;
  logic       cnt_q, cnt_d;
`ifdef HAZARD_DIV_HOLD_EN
  logic [5:0] wait_q, wait_d;
`endif

  logic       uses_rs1, uses_rs2, is_branch, ex_match, mem_match;
  logic [1:0] need_n;
  logic       stall_cyc, div_hold;

  always_comb begin
    uses_rs1  = !((opcode_id == OP_LUI) || (opcode_id == OP_AUIPC) || (opcode_id == OP_JAL));
    uses_rs2  = (opcode_id == OP_R) || (opcode_id == OP_STORE) ||
                (opcode_id == OP_BRANCH) || (opcode_id == OP_AMO);
    is_branch = (opcode_id == OP_BRANCH) || (opcode_id == OP_JALR);
    ex_match  = (rd_ex != 5'd0) &&
                ((uses_rs1 && (rs1_id == rd_ex)) || (uses_rs2 && (rs2_id == rd_ex)));
    mem_match = (rd_mem != 5'd0) &&
                ((uses_rs1 && (rs1_id == rd_mem)) || (uses_rs2 && (rs2_id == rd_mem)));
    need_n = 2'd0;
    if (is_branch) begin
      if (ex_match && mem_to_reg_ex)        need_n = 2'd2;
      else if (ex_match && reg_write_ex)    need_n = 2'd1;
      else if (mem_match && mem_to_reg_mem) need_n = 2'd1;
    end else if (ex_match && mem_to_reg_ex) begin
      need_n = 2'd1;
    end
  end

  // HOLD decrements first so a count of 1 yields exactly one extra stall cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_cyc = 1'b0;
    div_hold  = 1'b0;
`ifdef HAZARD_DIV_HOLD_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      RUN: begin
`ifdef HAZARD_DIV_HOLD_EN
        if (div_start_ex && !div_done) begin
          div_hold = 1'b1;
          state_d  = DIV_WAIT;
          wait_d   = 6'd0;
        end else begin
`else
        begin
`endif
          stall_cyc = (need_n != 2'd0);
          if (need_n == 2'd2) begin
            state_d = HOLD;
            cnt_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        stall_cyc = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_d == 1'b0) state_d = RUN;
      end
`ifdef HAZARD_DIV_HOLD_EN
      DIV_WAIT: begin
        if (div_done) begin
          stall_cyc = (need_n != 2'd0);
          state_d   = RUN;
          wait_d    = 6'd0;
        end else begin
          div_hold = 1'b1;
          wait_d   = wait_q + 6'd1;
          if (wait_q == DIV_LIM) begin
            state_d = RUN;
            wait_d  = 6'd0;
          end
        end
      end
`endif
      default: begin
        state_d = RUN;
        cnt_d   = 1'b0;
      end
    endcase
    if (reset) begin
      stall_cyc = 1'b0;
      div_hold  = 1'b0;
    end
  end

  assign pc_en        = !(stall_cyc || div_hold);
  assign if_id_en     = !(stall_cyc || div_hold);
  assign id_ex_flush  = stall_cyc && !div_hold;
  assign stall        = !pc_en;
`ifdef HAZARD_DIV_HOLD_EN
  assign id_ex_en     = !div_hold;
  assign ex_mem_flush = div_hold;
`else
  assign id_ex_en     = 1'b1;
  assign ex_mem_flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 1'b0;
`ifdef HAZARD_DIV_HOLD_EN
      wait_q  <= 6'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef HAZARD_DIV_HOLD_EN
      wait_q  <= wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; divide-hold steps follow HAZARD_DIV_HOLD_EN.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcodeId;
  logic [4:0] rs1Id, rs2Id, rdEx, rdMem;
  logic       regWriteEx, memToRegEx, memToRegMem;
  logic       divStartEx, divDone;
  logic       pcEn, ifIdEn, idExEn, idExFlush, exMemFlush, stall;

  int nCompared   = 0;
  int nMismatched = 0;

  // Expected vectors ordered {pc_en, if_id_en, id_ex_en, id_ex_flush, ex_mem_flush, stall}
  localparam logic [5:0] IDLE  = 6'b111000;
  localparam logic [5:0] STALL = 6'b001101;
  localparam logic [5:0] DIVH  = 6'b000011;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  hazard_ctrl #(.DIV_LAT_MAX(34)) dut (
    .clk(clk), .reset(reset), .opcode_id(opcodeId), .rs1_id(rs1Id), .rs2_id(rs2Id),
    .rd_ex(rdEx), .reg_write_ex(regWriteEx), .mem_to_reg_ex(memToRegEx),
    .rd_mem(rdMem), .mem_to_reg_mem(memToRegMem), .div_start_ex(divStartEx),
    .div_done(divDone), .pc_en(pcEn), .if_id_en(ifIdEn), .id_ex_en(idExEn),
    .id_ex_flush(idExFlush), .ex_mem_flush(exMemFlush), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rdE, input logic rwE, input logic mrE,
                               input logic [4:0] rdM, input logic mrM);
    opcodeId = op; rs1Id = r1; rs2Id = r2;
    rdEx = rdE; regWriteEx = rwE; memToRegEx = mrE;
    rdMem = rdM; memToRegMem = mrM;
  endtask

  task automatic applyIdle();
    applyStimulus(OP_R, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Checks combinational outputs mid-cycle, then steps to just after the next edge.
  task automatic checkOutput(input string tag, input logic [5:0] expVec);
    logic [5:0] obs;
    @(negedge clk);
    obs = {pcEn, ifIdEn, idExEn, idExFlush, exMemFlush, stall};
    nCompared++;
    assert (obs === expVec) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expVec);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; divStartEx = 1'b0; divDone = 1'b0;
    applyStimulus(OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("reset_idle", IDLE);
    reset = 1'b0;
    checkOutput("load_use_rs1", STALL);
    applyStimulus(OP_R, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    checkOutput("load_use_release", IDLE);

    applyStimulus(OP_BRANCH, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("br_load_run", STALL);
    applyIdle();
    checkOutput("br_load_hold", STALL);
    checkOutput("br_load_release", IDLE);

    applyStimulus(OP_BRANCH, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("br_alu_ex", STALL);
    applyIdle();
    checkOutput("br_alu_release", IDLE);

    applyStimulus(OP_BRANCH, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    checkOutput("br_mem_load", STALL);
    applyIdle();
    checkOutput("br_mem_release", IDLE);

    applyStimulus(OP_BRANCH, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1);
    checkOutput("x0_no_stall", IDLE);
    applyStimulus(OP_JAL, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);
    checkOutput("jal_no_stall", IDLE);
    applyStimulus(OP_LUI, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("lui_no_stall", IDLE);
    applyStimulus(OP_STORE, 5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("sw_rs2_stall", STALL);
    applyIdle();
    checkOutput("sw_release", IDLE);

    applyStimulus(OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("alu_ex_nonbranch", IDLE);
    applyStimulus(OP_I, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("itype_rs2_unused", IDLE);
    applyStimulus(OP_R, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("r_rs2_load_use", STALL);
    applyIdle();
    checkOutput("r_rs2_release", IDLE);

    applyStimulus(OP_JALR, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("jalr_load_run", STALL);
    applyIdle();
    checkOutput("jalr_load_hold", STALL);
    checkOutput("jalr_release", IDLE);

    applyStimulus(OP_BRANCH, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("rst_hold_entry", STALL);
    reset = 1'b1;
    applyIdle();
    checkOutput("rst_during_hold", IDLE);
    reset = 1'b0;
    checkOutput("rst_after_hold", IDLE);

`ifdef HAZARD_DIV_HOLD_EN
    applyIdle();
    divStartEx = 1'b1; divDone = 1'b0;
    for (int i = 0; i < 33; i++) checkOutput("div_hold", DIVH);
    divDone = 1'b1;
    checkOutput("div_release", IDLE);
    divStartEx = 1'b0; divDone = 1'b0;
    checkOutput("div_after", IDLE);

    applyStimulus(OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    divStartEx = 1'b1;
    checkOutput("div_priority", DIVH);
    divDone = 1'b1;
    checkOutput("div_exit_hazard", STALL);
    applyIdle();
    divStartEx = 1'b0; divDone = 1'b0;
    checkOutput("div_exit_clear", IDLE);

    divStartEx = 1'b1; divDone = 1'b1;
    checkOutput("div_start_and_done", IDLE);
    divDone = 1'b0;
    for (int i = 0; i < 35; i++) checkOutput("div_watchdog_hold", DIVH);
    divStartEx = 1'b0;
    checkOutput("div_watchdog_exit", IDLE);
`else
    applyIdle();
    divStartEx = 1'b1; divDone = 1'b0;
    checkOutput("div_ignored", IDLE);
    checkOutput("div_ignored_2", IDLE);
    divStartEx = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32IMA core. Sits between ID decode and the pipeline register enables. Detects load-use and branch/JALR operand hazards and sequences the 1- or 2-cycle stalls they need. Optionally holds the pipeline while a multi-cycle M-extension divide completes in EX. It is the sole source of `stall`, PC/IF-ID enables and the ID/EX bubble.

## Interface
- `DIV_LAT_MAX`, default 34: divide watchdog limit in cycles. Only used when `HAZARD_DIV_HOLD_EN` is defined.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode_id` in 7: opcode of the instruction in ID.
- `rs1_id`, `rs2_id` in 5 each: source registers in ID.
- `rd_ex` in 5: destination register in EX.
- `reg_write_ex` in 1: EX instruction writes rd.
- `mem_to_reg_ex` in 1: EX instruction is a load.
- `rd_mem` in 5: destination register in MEM.
- `mem_to_reg_mem` in 1: MEM instruction is a load.
- `div_start_ex` in 1: DIV/DIVU/REM/REMU is in EX. Ignored without the macro.
- `div_done` in 1: divider result valid this cycle. Ignored without the macro.
- `pc_en` out 1: PC register enable.
- `if_id_en` out 1: IF/ID register enable.
- `id_ex_en` out 1: ID/EX register enable.
- `id_ex_flush` out 1: load a bubble (NOP) into ID/EX.
- `ex_mem_flush` out 1: load a bubble into EX/MEM.
- `stall` out 1: equal to `!pc_en`.

## Operation
- Operand use decoded from `opcode_id`:
  - rs1 used: every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111.
  - rs2 used: R 0110011, STORE 0100011, BRANCH 1100011, AMO 0101111.
- A match requires the register to be used, equal to the producer's rd, and rd != 0. x0 never causes a stall.
- Required stall count N, evaluated in RUN only:
  - BRANCH or JALR in ID, EX match with `mem_to_reg_ex`: N=2.
  - BRANCH or JALR in ID, EX match with `reg_write_ex` and not load: N=1.
  - BRANCH or JALR in ID, MEM match with `mem_to_reg_mem`: N=1.
  - Any other opcode, EX match with `mem_to_reg_ex` (load-use): N=1.
  - Otherwise N=0. JAL always gives N=0.
- FSM states: RUN, HOLD, DIV_WAIT. Each cycle below is listed with its outputs; any signal not listed is idle.
- Idle outputs: `pc_en`=`if_id_en`=`id_ex_en`=1, flushes 0.
- Stall cycle outputs: `pc_en`=`if_id_en`=0, `id_ex_en`=1, `id_ex_flush`=1.
- RUN with N>0: stall cycle this cycle. If N=2, set `cnt`<=1 and go to HOLD.
- HOLD: stall cycle. Inputs are ignored. `cnt` decrements; go to RUN when `cnt`==0 at the edge. HOLD always lasts exactly 1 cycle.
- Hazard stalls never exceed 2 consecutive cycles.

## Timing
- Hazard outputs are combinational from state and inputs in RUN. The first stall is asserted in the same cycle the hazard is presented.
- Reset:
  - State RUN, `cnt`=0.
  - Outputs while `reset`=1: `pc_en`=`if_id_en`=`id_ex_en`=1, `id_ex_flush`=`ex_mem_flush`=0, `stall`=0.
  - `reset` asserted in HOLD or DIV_WAIT: RUN on the next edge, no residual stall.
- Unreachable state encodings return to RUN on the next edge.

## Configuration
- `HAZARD_DIV_HOLD_EN` defined:
  - RUN with `div_start_ex`=1 and `div_done`=0: enter DIV_WAIT.
  - Divide priority: a div hold overrides any hazard stall in the same cycle.
  - DIV_WAIT outputs, applied in the entry cycle and every cycle in DIV_WAIT: `pc_en`=`if_id_en`=`id_ex_en`=0, `ex_mem_flush`=1, `id_ex_flush`=0.
  - Exit: the cycle `div_done`=1 releases all holds and the hazard check is re-evaluated that cycle; state RUN next edge.
  - `div_start_ex` and `div_done` both 1 in RUN: no hold.
  - Watchdog: a 6-bit wait counter forces RUN after `DIV_LAT_MAX` cycles in DIV_WAIT.
- Macro undefined:
  - Divide inputs are ignored and DIV_WAIT, the wait counter and the watchdog are absent.
  - `ex_mem_flush` tied 0; `id_ex_en` tied 1.

## Test plan
- `lw x5` in EX (`mem_to_reg_ex`=1, `rd_ex`=5), `add x6,x5,x1` in ID -> `stall`=1 for exactly 1 cycle with `id_ex_flush`=1, then `pc_en`=1.
- `lw x5` in EX, `beq x5,x2` in ID -> `stall`=1 for exactly 2 cycles (RUN then HOLD), then 0; an `add` to x5 in EX instead -> 1 cycle.
- `rd_ex`=0 with load, `beq x0,x0` in ID -> no stall. `jal` in ID with a load to any rd in EX -> no stall.
- `lw x7` in EX, `lui x7` in ID -> no stall. `sw x7,0(x3)` in ID -> 1 stall via rs2.
- Macro on: `div_start_ex`=1, `div_done` rises after 33 cycles -> `pc_en`=`id_ex_en`=0 and `ex_mem_flush`=1 for 33 cycles, all released in the `div_done` cycle.
- `reset` asserted during HOLD -> next cycle `stall`=0, state RUN.
